yarp_decode_pipe: RTL and testbench

Registered, parametrised successor to the combinational instruction decoder. Sits between fetch and execute: accepts raw instructions with their PC on a valid/ready handshake, decodes fields, instruction type and sign-extended immediate, and holds the results in a DEPTH-entry FIFO. Adds illegal-opcode detection, an optional custom-0 opcode class for the AES extension instructions, and a pipeline flush.

---
 rtl/yarp_decode_pipe.sv | 166 ++++++++++++++++
 tb/tb_yarp_decode_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_decode_pipe.sv
// Decode stage between fetch and execute: decodes each accepted instruction
// and queues the full decoded record in a DEPTH-entry FIFO with flush.
module yarp_decode_pipe #(
    parameter int DEPTH     = 2,
    parameter int PC_W      = 32,
    parameter int CUSTOM_EN = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [31:0]                    in_instr_i,
    input  logic [PC_W-1:0]                in_pc_i,
    input  logic                           flush_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [PC_W-1:0]                out_pc_o,
    output logic [4:0]                     out_rs1_o,
    output logic [4:0]                     out_rs2_o,
    output logic [4:0]                     out_rd_o,
    output logic [6:0]                     out_op_o,
    output logic [2:0]                     out_funct3_o,
    output logic [6:0]                     out_funct7_o,
    output logic [6:0]                     out_type_o,
    output logic                           out_illegal_o,
    output logic [31:0]                    out_imm_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // record layout: {pc, raw instr, type, illegal, imm}
    localparam int REC_W = PC_W + 72;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_CUSTOM = 7'b0001011;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [6:0]       w_type;
    logic             w_illegal;
    logic [31:0]      w_imm;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_out;
    logic [31:0]      w_out_instr;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Combinational decode of the incoming instruction
    always_comb begin
        w_type    = 7'b0000000;
        w_illegal = 1'b0;
        w_imm     = 32'h0000_0000;
        case (in_instr_i[6:0])
            OP_R: w_type = 7'b0000001;
            OP_I_ALU, OP_LOAD, OP_JALR: begin
                w_type = 7'b0000010;
                w_imm  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            end
            OP_S: begin
                w_type = 7'b0000100;
                w_imm  = {{21{in_instr_i[31]}}, in_instr_i[30:25], in_instr_i[11:7]};
            end
            OP_B: begin
                w_type = 7'b0001000;
                w_imm  = {{20{in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25],
                          in_instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_type = 7'b0010000;
                w_imm  = {in_instr_i[31:12], 12'h000};
            end
            OP_J: begin
                w_type = 7'b0100000;
                w_imm  = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                          in_instr_i[30:21], 1'b0};
            end
            OP_CUSTOM: begin
                if (CUSTOM_EN != 0) begin
                    w_type = 7'b1000000;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_rec      = {in_pc_i, in_instr_i, w_type, w_illegal, w_imm};
    // ready looks only at the registered count, so a pop never frees a slot the same cycle
    assign in_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_push     = in_valid_i & in_ready_o & ~flush_i;
    assign w_pop      = out_valid_o & out_ready_i & ~flush_i;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Decoded-record storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign count_o     = r_count;
    assign out_valid_o = (r_count != '0);
    assign w_out       = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign w_out_instr = w_out[71:40];

    assign out_pc_o      = w_out[REC_W-1:72];
    assign out_funct7_o  = w_out_instr[31:25];
    assign out_rs2_o     = w_out_instr[24:20];
    assign out_rs1_o     = w_out_instr[19:15];
    assign out_funct3_o  = w_out_instr[14:12];
    assign out_rd_o      = w_out_instr[11:7];
    assign out_op_o      = w_out_instr[6:0];
    assign out_type_o    = w_out[39:33];
    assign out_illegal_o = w_out[32];
    assign out_imm_o     = w_out[31:0];

endmodule

// File: tb/tb_yarp_decode_pipe.sv
// Bench for yarp_decode_pipe: directed scenarios plus random traffic checked
// against a queue-based reference model (DEPTH=3 instance) and a DEPTH=1 instance.
module tb_yarp_decode_pipe;

    logic clk;
    logic reset_n;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
    logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
    logic [6:0]  a_out_op, a_out_funct7, a_out_type;
    logic [2:0]  a_out_funct3;
    logic [1:0]  a_count;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
    logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
    logic [6:0]  b_out_op, b_out_funct7, b_out_type;
    logic [2:0]  b_out_funct3;
    logic [0:0]  b_count;

    int total = 0;
    int bad   = 0;
    logic [103:0] mq[$];

    yarp_decode_pipe #(.DEPTH(3), .PC_W(32), .CUSTOM_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_instr_i(a_in_instr),
        .in_pc_i(a_in_pc), .flush_i(a_flush), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_pc_o(a_out_pc), .out_rs1_o(a_out_rs1),
        .out_rs2_o(a_out_rs2), .out_rd_o(a_out_rd), .out_op_o(a_out_op),
        .out_funct3_o(a_out_funct3), .out_funct7_o(a_out_funct7), .out_type_o(a_out_type),
        .out_illegal_o(a_out_illegal), .out_imm_o(a_out_imm), .count_o(a_count)
    );

    yarp_decode_pipe #(.DEPTH(1), .PC_W(32), .CUSTOM_EN(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_instr_i(b_in_instr),
        .in_pc_i(b_in_pc), .flush_i(b_flush), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .out_pc_o(b_out_pc), .out_rs1_o(b_out_rs1),
        .out_rs2_o(b_out_rs2), .out_rd_o(b_out_rd), .out_op_o(b_out_op),
        .out_funct3_o(b_out_funct3), .out_funct7_o(b_out_funct7), .out_type_o(b_out_type),
        .out_illegal_o(b_out_illegal), .out_imm_o(b_out_imm), .count_o(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected visible record {pc, funct7..op (= raw instr), type, illegal, imm}
    function automatic logic [103:0] exp_of(input logic [31:0] pc, input logic [31:0] ins,
                                            input bit cen);
        logic [6:0]         t;
        logic               ill;
        int                 imm;
        logic signed [11:0] s12;
        logic signed [19:0] s20;
        t = 7'd0; ill = 1'b0; imm = 0;
        case (ins[6:0])
            7'b0110011: t = 7'b0000001;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                t = 7'b0000010; s12 = ins[31:20]; imm = int'(s12);
            end
            7'b0100011: begin
                t = 7'b0000100; s12 = {ins[31:25], ins[11:7]}; imm = int'(s12);
            end
            7'b1100011: begin
                t = 7'b0001000; s12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
                imm = int'(s12) * 2;
            end
            7'b0110111, 7'b0010111: begin
                t = 7'b0010000; imm = int'(ins & 32'hFFFF_F000);
            end
            7'b1101111: begin
                t = 7'b0100000; s20 = {ins[31], ins[19:12], ins[20], ins[30:21]};
                imm = int'(s20) * 2;
            end
            7'b0001011: begin
                if (cen) t = 7'b1000000;
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        return {pc, ins, t, ill, 32'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        logic [103:0] obs;
        obs = {a_out_pc, a_out_funct7, a_out_rs2, a_out_rs1, a_out_funct3, a_out_rd,
               a_out_op, a_out_type, a_out_illegal, a_out_imm};
        chk("a_count", 128'(a_count), 128'(mq.size()));
        chk("a_out_valid", 128'(a_out_valid), 128'(mq.size() != 0));
        chk("a_in_ready", 128'(a_in_ready), 128'(mq.size() < 3));
        chk("a_head", 128'(obs), (mq.size() != 0) ? 128'(mq[0]) : 128'd0);
    endtask

    task automatic check_b(input string tag, input logic [0:0] cnt, input logic [103:0] exp);
        logic [103:0] obs;
        obs = {b_out_pc, b_out_funct7, b_out_rs2, b_out_rs1, b_out_funct3, b_out_rd,
               b_out_op, b_out_type, b_out_illegal, b_out_imm};
        chk({tag, "_count"}, 128'(b_count), 128'(cnt));
        chk({tag, "_valid"}, 128'(b_out_valid), 128'(cnt));
        chk({tag, "_ready"}, 128'(b_in_ready), 128'(!cnt));
        chk({tag, "_head"}, 128'(obs), 128'(exp));
    endtask

    // One clock: model follows the queue semantics of the stage, then outputs are compared
    task automatic tick();
        bit           push, pop, fl;
        logic [103:0] rec;
        push = a_in_valid && (mq.size() < 3) && !a_flush;
        pop  = (mq.size() != 0) && a_out_ready && !a_flush;
        fl   = a_flush;
        rec  = exp_of(a_in_pc, a_in_instr, 1'b1);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(rec);
        end
        #1;
        check_a();
    endtask

    logic [31:0] seq_instr [4];
    logic [31:0] seq_imm   [4];
    logic [6:0]  ops [11];
    logic [31:0] r;
    logic [6:0]  op;

    initial begin
        seq_instr = '{32'hFE112E23, 32'hFE000EE3, 32'h123452B7, 32'hFFDFF06F};
        seq_imm   = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0001011, 7'b0000000};
        reset_n = 1'b0;
        a_in_valid = 1'b0; a_in_instr = 32'd0; a_in_pc = 32'd0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_pc = 32'd0; b_flush = 1'b0; b_out_ready = 1'b0;
        #2;
        check_a();
        check_b("b_reset", 1'b0, 104'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // addi x5,x6,10 through an empty stage
        a_in_valid = 1'b1; a_in_instr = 32'h00A30293; a_in_pc = 32'h100; a_out_ready = 1'b1;
        tick();
        chk("addi_valid", 128'(a_out_valid), 128'd1);
        chk("addi_type", 128'(a_out_type), 128'(7'b0000010));
        chk("addi_imm", 128'(a_out_imm), 128'(32'h0000000A));
        chk("addi_rd", 128'(a_out_rd), 128'd5);
        chk("addi_rs1", 128'(a_out_rs1), 128'd6);
        chk("addi_pc", 128'(a_out_pc), 128'(32'h100));
        a_in_valid = 1'b0;
        tick();
        chk("addi_drained", 128'(a_out_valid), 128'd0);

        // S, B, U, J back to back, one per cycle
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_instr = seq_instr[i]; a_in_pc = 32'h200 + 32'(4 * i);
            tick();
            chk("seq_imm", 128'(a_out_imm), 128'(seq_imm[i]));
            chk("seq_count", 128'(a_count), 128'd1);
        end
        a_in_valid = 1'b0;
        tick();

        // custom-0 on both instances, then all-zero instruction
        a_in_valid = 1'b1; a_in_instr = 32'h0020850B; a_in_pc = 32'h300;
        b_in_valid = 1'b1; b_in_instr = 32'h0020850B; b_in_pc = 32'h300;
        tick();
        chk("cust_type", 128'(a_out_type), 128'(7'b1000000));
        chk("cust_ill", 128'(a_out_illegal), 128'd0);
        chk("cust_imm", 128'(a_out_imm), 128'd0);
        chk("b_cust_type", 128'(b_out_type), 128'd0);
        chk("b_cust_ill", 128'(b_out_illegal), 128'd1);
        check_b("b_full", 1'b1, exp_of(32'h300, 32'h0020850B, 1'b0));
        a_in_instr = 32'h00000000;
        // full DEPTH=1 instance: pop happens, the presented instruction must not enter
        b_in_instr = 32'h00A30293; b_in_pc = 32'h304; b_out_ready = 1'b1;
        tick();
        chk("zero_ill", 128'(a_out_illegal), 128'd1);
        chk("zero_imm", 128'(a_out_imm), 128'd0);
        check_b("b_popfull", 1'b0, 104'd0);
        b_in_valid = 1'b1;
        tick();
        check_b("b_refill", 1'b1, exp_of(32'h304, 32'h00A30293, 1'b0));
        b_in_valid = 1'b0;
        a_in_valid = 1'b0;
        tick();
        check_b("b_empty", 1'b0, 104'd0);

        // fill DEPTH=3 with consumer stalled, then stream across pointer wrap
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in_instr = 32'h00100093 + 32'(i << 20); a_in_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        chk("full_count", 128'(a_count), 128'd3);
        chk("full_ready", 128'(a_in_ready), 128'd0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_instr = 32'h00500113 + 32'(i << 20); a_in_pc = 32'h500 + 32'(4 * i);
            tick();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // flush with a pending push
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_in_instr = 32'h00000033 + 32'(i << 7); a_in_pc = 32'h600 + 32'(4 * i);
            tick();
        end
        a_flush = 1'b1; a_in_instr = 32'h12345037;
        tick();
        chk("flush_count", 128'(a_count), 128'd0);
        chk("flush_valid", 128'(a_out_valid), 128'd0);
        chk("flush_ready", 128'(a_in_ready), 128'd1);
        a_flush = 1'b0; a_in_valid = 1'b0;
        tick();
        chk("flush_nostore", 128'(a_count), 128'd0);

        // asynchronous reset with two entries held
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_in_instr = 32'hFE000EE3; a_in_pc = 32'h700 + 32'(4 * i);
            tick();
        end
        a_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        mq.delete();
        check_a();
        chk("rst_count", 128'(a_count), 128'd0);
        #2 reset_n = 1'b1;
        tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 10)];
            if (op == 7'b0000000) op = r[6:0];
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_instr  = {r[31:7], op};
            a_in_pc     = $urandom();
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
